conv_sched: RTL and testbench

Layer-level sequencer for the convolution core. It runs a layer of `num_grp` filter groups (4 filters each, one per weight bus) over `num_ch` input channels. It kicks the weight-load controller (`init`), waits for its `buffer_ready`, and issues one `ch_start` per channel plane to the pipeline. From the pipeline's `ch_done` it generates the `channel_end`/`core_end` pulses whose AND makes the weight-load controller swap in the next group's weights.

---
 rtl/conv_sched_if.sv | 34 +++
 rtl/conv_sched.sv | 153 +++++++++++++++
 tb/tb_conv_sched.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_sched_if.sv
// Handshake and status bundle between the layer sequencer and its surroundings
// (host control, weight-load controller, convolution pipeline).
interface conv_sched_if #(
  parameter int CH_W  = 8,
  parameter int GRP_W = 8
);
  logic             start;
  logic             abort;
  logic [CH_W-1:0]  num_ch;
  logic [GRP_W-1:0] num_grp;
  logic             buffer_ready;
  logic             ch_done;
  logic             init;
  logic             ch_start;
  logic             core_end;
  logic             channel_end;
  logic [CH_W-1:0]  ch_idx;
  logic [GRP_W-1:0] grp_idx;
  logic             busy;
  logic             layer_done;
  logic             cfg_err;

  modport master (
    output start, abort, num_ch, num_grp, buffer_ready, ch_done,
    input  init, ch_start, core_end, channel_end, ch_idx, grp_idx,
           busy, layer_done, cfg_err
  );

  modport slave (
    input  start, abort, num_ch, num_grp, buffer_ready, ch_done,
    output init, ch_start, core_end, channel_end, ch_idx, grp_idx,
           busy, layer_done, cfg_err
  );
endinterface

// File: rtl/conv_sched.sv
// Layer sequencer: kicks the weight load, issues one ch_start per channel plane
// and turns pipeline ch_done pulses into core_end/channel_end/layer_done.
module conv_sched #(
  parameter int CH_W     = 8,
  parameter int GRP_W    = 8,
  parameter int SWAP_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  conv_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_BUF, ISSUE, RUN, GAP, DONE} state_t;

  localparam logic [3:0] GAP_LAST = 4'(SWAP_GAP - 1);

  state_t           state_q, state_d;
  logic [CH_W-1:0]  ch_idx_q, ch_idx_d, num_ch_q, num_ch_d;
  logic [GRP_W-1:0] grp_idx_q, grp_idx_d, num_grp_q, num_grp_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             init_q, init_d;
  logic             ch_start_q, ch_start_d;
  logic             core_end_q, core_end_d;
  logic             channel_end_q, channel_end_d;
  logic             busy_q, busy_d;
  logic             layer_done_q, layer_done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             ch_last, grp_last;

  assign ch_last  = (ch_idx_q == num_ch_q - CH_W'(1));
  assign grp_last = (grp_idx_q == num_grp_q - GRP_W'(1));

  always_comb begin
    state_d       = state_q;
    ch_idx_d      = ch_idx_q;
    grp_idx_d     = grp_idx_q;
    num_ch_d      = num_ch_q;
    num_grp_d     = num_grp_q;
    gap_cnt_d     = gap_cnt_q;
    init_d        = 1'b0;
    ch_start_d    = 1'b0;
    core_end_d    = 1'b0;
    channel_end_d = 1'b0;
    layer_done_d  = 1'b0;
    busy_d        = busy_q;
    cfg_err_d     = cfg_err_q;
    if (bus.abort) begin
      // abort outranks everything, including a same-cycle start; cfg_err is kept
      state_d   = IDLE;
      busy_d    = 1'b0;
      ch_idx_d  = '0;
      grp_idx_d = '0;
      gap_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          busy_d = 1'b0;
          if (bus.start) begin
            if ((bus.num_ch != '0) && (bus.num_grp != '0)) begin
              num_ch_d  = bus.num_ch;
              num_grp_d = bus.num_grp;
              ch_idx_d  = '0;
              grp_idx_d = '0;
              cfg_err_d = 1'b0;
              init_d    = 1'b1;
              busy_d    = 1'b1;
              state_d   = WAIT_BUF;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        WAIT_BUF: if (bus.buffer_ready) state_d = ISSUE;
        ISSUE: begin
          ch_start_d = 1'b1;
          state_d    = RUN;
        end
        RUN: begin
          if (bus.ch_done) begin
            core_end_d = 1'b1;
            if (!ch_last) begin
              ch_idx_d = ch_idx_q + CH_W'(1);
              state_d  = ISSUE;
            end else if (!grp_last) begin
              channel_end_d = 1'b1;
              ch_idx_d      = '0;
              grp_idx_d     = grp_idx_q + GRP_W'(1);
              gap_cnt_d     = '0;
              state_d       = GAP;
            end else begin
              channel_end_d = 1'b1;
              state_d       = DONE;
            end
          end
        end
        // buffer_ready stays high after the first load, so a group swap only
        // needs the fixed latch gap rather than another WAIT_BUF visit
        GAP: begin
          if (gap_cnt_q == GAP_LAST) state_d = ISSUE;
          else gap_cnt_d = gap_cnt_q + 4'd1;
        end
        DONE: begin
          layer_done_d = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ch_idx_q      <= '0;
      grp_idx_q     <= '0;
      gap_cnt_q     <= '0;
      init_q        <= 1'b0;
      ch_start_q    <= 1'b0;
      core_end_q    <= 1'b0;
      channel_end_q <= 1'b0;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_idx_q      <= ch_idx_d;
      grp_idx_q     <= grp_idx_d;
      gap_cnt_q     <= gap_cnt_d;
      init_q        <= init_d;
      ch_start_q    <= ch_start_d;
      core_end_q    <= core_end_d;
      channel_end_q <= channel_end_d;
      busy_q        <= busy_d;
      layer_done_q  <= layer_done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  // latched counts are only read while busy, so they need no reset
  always_ff @(posedge clk) begin
    num_ch_q  <= num_ch_d;
    num_grp_q <= num_grp_d;
  end

  assign bus.init        = init_q;
  assign bus.ch_start    = ch_start_q;
  assign bus.core_end    = core_end_q;
  assign bus.channel_end = channel_end_q;
  assign bus.ch_idx      = ch_idx_q;
  assign bus.grp_idx     = grp_idx_q;
  assign bus.busy        = busy_q;
  assign bus.layer_done  = layer_done_q;
  assign bus.cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: drives layers with a scripted weight loader and pipeline,
// predicting event order and cycle timing from the layer configuration.
module tb_conv_sched;
  localparam int CH_W     = 8;
  localparam int GRP_W    = 8;
  localparam int SWAP_GAP = 2;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;

  conv_sched_if #(.CH_W(CH_W), .GRP_W(GRP_W)) bus ();

  conv_sched #(.CH_W(CH_W), .GRP_W(GRP_W), .SWAP_GAP(SWAP_GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [22:0] outs();
    return {bus.init, bus.ch_start, bus.core_end, bus.channel_end, bus.busy,
            bus.layer_done, bus.cfg_err, bus.ch_idx, bus.grp_idx};
  endfunction

  task automatic idle_inputs();
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.num_ch       = '0;
    bus.num_grp      = '0;
    bus.buffer_ready = 1'b0;
    bus.ch_done      = 1'b0;
  endtask

  // mode: 0 normal, 1 spurious ch_done/start, 2 abort in grp1 ch1, 3 async reset in GAP
  task automatic run_layer(input int nc, input int ng, input int br_delay,
                           input bit rand_lat, input int mode, input string tag);
    int start_cyc, init_cyc, br_cyc, done_due, last_done, last_done_ch, last_done_grp;
    int n_init, n_start, n_core, n_cend, n_ld, ld_cyc, abort_due, abort_cyc;
    int exp_ch, exp_grp, exp_cyc, limit;
    bit busy_exp, finished, spur, spur_start, do_rst;
    init_cyc = -1; br_cyc = -1; done_due = -1; last_done = -1;
    last_done_ch = -1; last_done_grp = -1; ld_cyc = -1; abort_due = -1; abort_cyc = -1;
    n_init = 0; n_start = 0; n_core = 0; n_cend = 0; n_ld = 0;
    busy_exp = 1'b1; finished = 1'b0; spur_start = 1'b0; do_rst = 1'b0;
    bus.buffer_ready = 1'b0;
    bus.ch_done      = 1'b0;
    bus.abort        = 1'b0;
    bus.num_ch       = CH_W'(nc);
    bus.num_grp      = GRP_W'(ng);
    bus.start        = 1'b1;
    start_cyc = cyc;
    limit = cyc + nc * ng * (20 + SWAP_GAP) + 80;
    while (!finished && cyc < limit) begin
      tick();
      bus.start = 1'b0; bus.ch_done = 1'b0; bus.abort = 1'b0;
      spur = 1'b0;
      if (abort_cyc >= 0 && cyc > abort_cyc) busy_exp = 1'b0;
      if (ld_cyc >= 0 && cyc > ld_cyc) busy_exp = 1'b0;
      tests++;
      if (bus.busy !== busy_exp) begin
        fails++; $display("FAIL %s_busy @%0d: got %0d expected %0d", tag, cyc, bus.busy, busy_exp);
      end
      if (bus.init) begin
        n_init++;
        if (init_cyc < 0) init_cyc = cyc;
        tests++;
        if (cyc != start_cyc + 1 || bus.cfg_err !== 1'b0) begin
          fails++; $display("FAIL %s_init: got cycle %0d cfg_err %0d expected cycle %0d cfg_err 0",
                            tag, cyc - start_cyc, bus.cfg_err, 1);
        end
      end
      if (bus.ch_start) begin
        if (abort_cyc >= 0) begin
          tests++; fails++;
          $display("FAIL %s_start_after_abort @%0d: got ch_start 1 expected 0", tag, cyc);
        end else begin
          exp_ch  = n_start % nc;
          exp_grp = n_start / nc;
          tests++;
          if (bus.ch_idx !== CH_W'(exp_ch) || bus.grp_idx !== GRP_W'(exp_grp)) begin
            fails++; $display("FAIL %s_idx: got ch %0d grp %0d expected ch %0d grp %0d",
                              tag, bus.ch_idx, bus.grp_idx, exp_ch, exp_grp);
          end
          if (n_start == 0)      exp_cyc = br_cyc + 2;
          else if (exp_ch == 0)  exp_cyc = last_done + 2 + SWAP_GAP;
          else                   exp_cyc = last_done + 2;
          tests++;
          if (cyc != exp_cyc) begin
            fails++; $display("FAIL %s_start_time #%0d: got cycle %0d expected %0d", tag, n_start, cyc, exp_cyc);
          end
          tests++;
          if (bus.core_end !== 1'b0) begin
            fails++; $display("FAIL %s_start_with_core_end: got core_end %0d expected 0", tag, bus.core_end);
          end
          n_start++;
          if (mode == 2 && n_start == nc + 2) begin
            abort_due = cyc + 2;
            done_due  = -1;
          end else begin
            done_due = cyc + (rand_lat ? int'($urandom_range(1, 12)) : 10);
          end
        end
      end
      if (bus.core_end) begin
        n_core++;
        tests++;
        if (cyc != last_done + 1) begin
          fails++; $display("FAIL %s_core_end_time: got cycle %0d expected %0d", tag, cyc, last_done + 1);
        end
      end
      if (bus.channel_end) begin
        n_cend++;
        tests++;
        if (bus.core_end !== 1'b1 || last_done_ch != nc - 1) begin
          fails++; $display("FAIL %s_channel_end: got core_end %0d ch %0d expected core_end 1 ch %0d",
                            tag, bus.core_end, last_done_ch, nc - 1);
        end
        if (mode == 1 && last_done_grp < ng - 1) spur = 1'b1;
        if (mode == 3 && last_done_grp < ng - 1) do_rst = 1'b1;
      end
      if (bus.layer_done) begin
        n_ld++;
        tests++;
        if (abort_cyc >= 0 || cyc != last_done + 2) begin
          fails++; $display("FAIL %s_layer_done_time: got cycle %0d expected %0d", tag, cyc, last_done + 2);
        end
        ld_cyc = cyc;
      end
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        tests++;
        if (outs() !== '0) begin
          fails++; $display("FAIL %s_abort_state: got %h expected 0", tag, outs());
        end
      end
      // drive the environment for this cycle
      if (init_cyc >= 0 && cyc >= init_cyc + br_delay) begin
        bus.buffer_ready = 1'b1;
        if (br_cyc < 0) br_cyc = cyc;
      end
      if (mode == 1 && cyc == init_cyc && br_delay >= 1) bus.ch_done = 1'b1;
      if (spur) bus.ch_done = 1'b1;
      if (cyc == done_due) begin
        bus.ch_done   = 1'b1;
        last_done     = cyc;
        last_done_ch  = (n_start - 1) % nc;
        last_done_grp = (n_start - 1) / nc;
        done_due      = -1;
      end
      if (mode == 1 && n_start == 2 && !spur_start) begin
        bus.start   = 1'b1;
        bus.num_ch  = CH_W'(nc + 3);
        bus.num_grp = GRP_W'(ng + 2);
        spur_start  = 1'b1;
      end
      if (cyc == abort_due) begin
        bus.abort = 1'b1;
        abort_cyc = cyc;
        abort_due = -1;
      end
      if (ld_cyc >= 0 && cyc >= ld_cyc + 3) finished = 1'b1;
      if (abort_cyc >= 0 && cyc >= abort_cyc + 30) finished = 1'b1;
      if (do_rst) begin
        #2 rst = 1'b0;
        #1;
        tests++;
        if (outs() !== '0) begin
          fails++; $display("FAIL %s_async_reset: got %h expected 0", tag, outs());
        end
        tick();
        tick();
        #2 rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
          tick();
          tests++;
          if (bus.ch_start !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL %s_after_reset: got ch_start %0d busy %0d expected 0 0",
                              tag, bus.ch_start, bus.busy);
          end
        end
        finished = 1'b1;
      end
    end
    tests++;
    if (!finished) begin
      fails++; $display("FAIL %s_timeout: got unfinished expected finished", tag);
    end else if (mode <= 1) begin
      if (n_init != 1 || n_start != nc * ng || n_core != nc * ng || n_cend != ng || n_ld != 1) begin
        fails++;
        $display("FAIL %s_counts: got init %0d start %0d core %0d chend %0d ld %0d expected 1 %0d %0d %0d 1",
                 tag, n_init, n_start, n_core, n_cend, n_ld, nc * ng, nc * ng, ng);
      end
    end else begin
      if (n_ld != 0 || (mode == 2 && abort_cyc < 0) || (mode == 3 && !do_rst)) begin
        fails++; $display("FAIL %s_no_layer_done: got ld %0d abort %0d expected 0", tag, n_ld, abort_cyc);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    tests++;
    if (outs() !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", outs());
    end
    bus.num_ch = 8'd3; bus.num_grp = 8'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    #2 rst = 1'b1;
    tick();
    tests++;
    if (outs() !== '0) begin
      fails++; $display("FAIL reset_release_idle: got %h expected 0", outs());
    end
  endtask

  task automatic test_basic();
    run_layer(3, 2, 5, 1'b0, 0, "basic");
  endtask

  task automatic test_single_ch();
    run_layer(1, 3, 2, 1'b0, 0, "single_ch");
  endtask

  task automatic test_cfg_err();
    idle_inputs();
    bus.num_ch = 8'd0; bus.num_grp = 8'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests++;
    if ({bus.cfg_err, bus.init, bus.busy} !== 3'b100) begin
      fails++; $display("FAIL cfg_err_set: got %b expected 100", {bus.cfg_err, bus.init, bus.busy});
    end
    tick();
    tick();
    tests++;
    if ({bus.cfg_err, bus.init, bus.busy} !== 3'b100) begin
      fails++; $display("FAIL cfg_err_sticky: got %b expected 100", {bus.cfg_err, bus.init, bus.busy});
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tests++;
    if (bus.cfg_err !== 1'b1) begin
      fails++; $display("FAIL cfg_err_abort_keeps: got %0d expected 1", bus.cfg_err);
    end
    bus.num_ch = 8'd4; bus.num_grp = 8'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests++;
    if ({bus.cfg_err, bus.init, bus.busy} !== 3'b100) begin
      fails++; $display("FAIL cfg_err_zero_grp: got %b expected 100", {bus.cfg_err, bus.init, bus.busy});
    end
    run_layer(2, 2, 3, 1'b1, 0, "cfg_recover");
  endtask

  task automatic test_spurious();
    run_layer(3, 3, 4, 1'b1, 1, "spurious");
  endtask

  task automatic test_abort();
    idle_inputs();
    bus.num_ch = 8'd2; bus.num_grp = 8'd2; bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    tests++;
    if ({bus.init, bus.busy} !== 2'b00) begin
      fails++; $display("FAIL abort_beats_start: got %b expected 00", {bus.init, bus.busy});
    end
    run_layer(3, 2, 1, 1'b0, 2, "abort");
    run_layer(2, 2, 3, 1'b1, 0, "after_abort");
  endtask

  task automatic test_async_reset();
    run_layer(2, 3, 2, 1'b0, 3, "async_rst");
    run_layer(2, 2, 1, 1'b0, 0, "after_rst");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      run_layer(int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 6)), 1'b1, 0, "random");
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst   = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_single_ch();
    test_cfg_err();
    test_spurious();
    test_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
